// File: rtl/dht_pkg.sv
// Shared state encodings, command codes and response codes for the DHT read scheduler.
// Also holds the frame validity check used in the CHECK state.
package dht_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_GAP_WAIT  = 3'd1;
    localparam state_t ST_START     = 3'd2;
    localparam state_t ST_WAIT_DONE = 3'd3;
    localparam state_t ST_CHECK     = 3'd4;
    localparam state_t ST_RESPOND   = 3'd5;

    localparam logic [1:0] CMD_HUM     = 2'b00;
    localparam logic [1:0] CMD_TEMP    = 2'b01;
    localparam logic [1:0] CMD_STATUS  = 2'b10;
    localparam logic [1:0] CMD_INVALID = 2'b11;

    localparam logic [7:0] RC_HUM    = 8'h00;
    localparam logic [7:0] RC_TEMP   = 8'h01;
    localparam logic [7:0] RC_STATUS = 8'h02;
    localparam logic [7:0] RC_ERR    = 8'h1F;
    localparam logic [7:0] RC_BADCMD = 8'hE0;

    // An all-ones frame is what a floating data line reads back, so it never counts as valid.
    function automatic logic frame_ok(input logic [39:0] f);
        logic [7:0] sum;
        sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        return (f != '1) && (sum == f[7:0]);
    endfunction

endpackage

// File: rtl/dht_gap_timer.sv
// Saturating gap counter: counts every cycle up to LIMIT, cleared by 'clear' or reset.
// Latency: elapsed is asserted in the cycle at whose end the count reaches LIMIT (or stays there).
// Backpressure: none; free-running.
module dht_gap_timer #(
    parameter int unsigned LIMIT = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic elapsed
);
    localparam int W = $clog2(LIMIT) + 1;
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;

    always_comb begin
        if (clear) begin
            cnt_nxt = '0;
        end else if (cnt >= LIM) begin
            cnt_nxt = LIM;
        end else begin
            cnt_nxt = cnt + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign elapsed = (cnt_nxt == LIM);

endmodule

// File: rtl/dht_read_scheduler.sv
// Schedules DHT sensor reads: enforces a minimum gap between accesses and a done timeout.
// Latency: sns_start 2 cycles after accept once the gap has elapsed; rsp_valid 1 cycle after CHECK.
// Backpressure: req_ready only in IDLE; the response is held stable until rsp_ready.
module dht_read_scheduler
    import dht_pkg::*;
#(
    parameter int unsigned GAP_CYCLES     = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_addr,
    input  logic [1:0]  req_cmd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [4:0]  rsp_addr,
    output logic [7:0]  rsp_code,
    output logic [15:0] rsp_data,
    output logic [4:0]  sns_sel,
    output logic        sns_start,
    input  logic        sns_done,
    input  logic [39:0] sns_data
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [4:0]    addr_q;
    logic [1:0]    cmd_q;
    logic [39:0]   frame_q;
    logic [TW-1:0] tcnt;
    logic          accept;
    logic          timeout;
    logic          gap_clear;
    logic          gap_elapsed;
    logic [7:0]    chk_code;
    logic [15:0]   chk_data;

    assign accept    = (state == ST_IDLE) && req_valid && req_ready;
    // tcnt counts cycles since the sns_start cycle, so the response lands TIMEOUT_CYCLES after it.
    assign timeout   = (tcnt == TO_LAST);
    assign gap_clear = (state == ST_WAIT_DONE) && (sns_done || timeout);
    assign rsp_valid = (state == ST_RESPOND);
    assign sns_start = (state == ST_START);

    dht_gap_timer #(
        .LIMIT (GAP_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (gap_clear),
        .elapsed (gap_elapsed)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (req_cmd == CMD_INVALID) ? ST_RESPOND : ST_GAP_WAIT;
                end
            end
            ST_GAP_WAIT: begin
                if (gap_elapsed) begin
                    state_nxt = ST_START;
                end
            end
            ST_START:     state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (sns_done) begin
                    state_nxt = ST_CHECK;
                end else if (timeout) begin
                    state_nxt = ST_RESPOND;
                end
            end
            ST_CHECK:     state_nxt = ST_RESPOND;
            ST_RESPOND: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        chk_code = RC_ERR;
        chk_data = 16'hFFFF;
        if (frame_ok(frame_q)) begin
            case (cmd_q)
                CMD_HUM: begin
                    chk_code = RC_HUM;
                    chk_data = frame_q[39:24];
                end
                CMD_TEMP: begin
                    chk_code = RC_TEMP;
                    chk_data = frame_q[23:8];
                end
                CMD_STATUS: begin
                    chk_code = RC_STATUS;
                    chk_data = 16'h0000;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            addr_q    <= '0;
            cmd_q     <= '0;
            frame_q   <= '0;
            tcnt      <= '0;
            rsp_addr  <= '0;
            rsp_code  <= '0;
            rsp_data  <= '0;
            sns_sel   <= '0;
        end else begin
            state     <= state_nxt;
            req_ready <= (state_nxt == ST_IDLE);

            if ((state == ST_START) || (state == ST_WAIT_DONE)) begin
                tcnt <= tcnt + TW'(1);
            end else begin
                tcnt <= '0;
            end

            if (accept) begin
                addr_q <= req_addr;
                cmd_q  <= req_cmd;
                if (req_cmd == CMD_INVALID) begin
                    rsp_addr <= req_addr;
                    rsp_code <= RC_BADCMD;
                    rsp_data <= 16'h0000;
                end
            end

            if ((state == ST_GAP_WAIT) && gap_elapsed) begin
                sns_sel <= addr_q;
            end

            if (state == ST_WAIT_DONE) begin
                if (sns_done) begin
                    frame_q <= sns_data;
                end else if (timeout) begin
                    rsp_addr <= addr_q;
                    rsp_code <= RC_ERR;
                    rsp_data <= 16'hFFFF;
                end
            end

            if (state == ST_CHECK) begin
                rsp_addr <= addr_q;
                rsp_code <= chk_code;
                rsp_data <= chk_data;
            end

            if ((state == ST_RESPOND) && rsp_ready) begin
                sns_sel <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dht_read_scheduler.sv
// Directed bench for dht_read_scheduler with a short gap and timeout.
// Timestamps are posedge counts since reset release, sampled on the falling edge.
module tb_dht_read_scheduler;
    localparam int unsigned GAP = 100;
    localparam int unsigned TMO = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_addr = '0;
    logic [1:0]  req_cmd = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [4:0]  rsp_addr;
    logic [7:0]  rsp_code;
    logic [15:0] rsp_data;
    logic [4:0]  sns_sel;
    logic        sns_start;
    logic        sns_done = 1'b0;
    logic [39:0] sns_data = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_starts = 0;

    localparam logic [39:0] FR_GOOD = 40'h35_00_1A_00_4F;
    localparam logic [39:0] FR_BAD  = 40'h35_00_1A_00_50;
    localparam logic [39:0] FR_ONES = 40'hFF_FF_FF_FF_FF;

    dht_read_scheduler #(
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_cmd   (req_cmd),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_addr  (rsp_addr),
        .rsp_code  (rsp_code),
        .rsp_data  (rsp_data),
        .sns_sel   (sns_sel),
        .sns_start (sns_start),
        .sns_done  (sns_done),
        .sns_data  (sns_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst_n && sns_start) n_starts <= n_starts + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Returns at the falling edge right after the accepting clock edge; acc_c is that edge's count.
    task automatic send_req(input logic [4:0] a, input logic [1:0] c, output int acc_c);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_cmd   = c;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_accept: req_ready never rose (actual 0, required 1)");
        end
        @(negedge clk);
        acc_c = cyc;
        req_valid = 1'b0;
    endtask

    // dly < 0 means the sensor never answers.
    task automatic sensor_reply(input logic [39:0] frame, input int dly,
                                output int start_c, output logic [4:0] sel, output int done_c);
        int n = 0;
        while (!sns_start && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sns_start !== 1'b1) begin
            errors++;
            $display("FAIL start_seen: sns_start never asserted (actual %b, required 1)", sns_start);
        end
        start_c = cyc;
        sel     = sns_sel;
        done_c  = -1;
        @(negedge clk);
        checks++;
        if (sns_start !== 1'b0) begin
            errors++;
            $display("FAIL start_pulse: sns_start still high next cycle (actual %b, required 0)", sns_start);
        end
        if (dly >= 0) begin
            repeat (dly - 1) @(negedge clk);
            sns_done = 1'b1;
            sns_data = frame;
            done_c   = cyc;
            @(negedge clk);
            sns_done = 1'b0;
            sns_data = '0;
        end
    endtask

    task automatic get_rsp(output int rc, output logic [4:0] a, output logic [7:0] code,
                           output logic [15:0] data);
        int n = 0;
        while (!rsp_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_seen: rsp_valid never asserted (actual %b, required 1)", rsp_valid);
        end
        rc   = cyc;
        a    = rsp_addr;
        code = rsp_code;
        data = rsp_data;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic check_rsp(input string name, input logic [4:0] a, input logic [7:0] code,
                             input logic [15:0] data, input logic [4:0] ea, input logic [7:0] ecode,
                             input logic [15:0] edata);
        checks++;
        if (a !== ea || code !== ecode || data !== edata) begin
            errors++;
            $display("FAIL %s: addr/code/data actual %0d/%h/%h, required %0d/%h/%h",
                     name, a, code, data, ea, ecode, edata);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, sns_start} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/valid/start actual %b, required 000",
                     {req_ready, rsp_valid, sns_start});
        end
        checks++;
        if (rsp_addr !== 5'd0 || rsp_code !== 8'h00 || rsp_data !== 16'h0000 || sns_sel !== 5'd0) begin
            errors++;
            $display("FAIL reset_data: addr/code/data/sel actual %0d/%h/%h/%0d, required 0/00/0000/0",
                     rsp_addr, rsp_code, rsp_data, sns_sel);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise: req_ready actual %b, required 1", req_ready);
        end
    endtask

    task automatic test_humidity();
        int acc, sc, dc, rc;
        logic [4:0] sel, a;
        logic [7:0] code;
        logic [15:0] data;
        send_req(5'd3, 2'b00, acc);
        sensor_reply(FR_GOOD, 1, sc, sel, dc);
        checks++;
        if (sc !== 100 || sel !== 5'd3) begin
            errors++;
            $display("FAIL first_start: cycle/sel actual %0d/%0d, required 100/3", sc, sel);
        end
        get_rsp(rc, a, code, data);
        checks++;
        if (rc !== dc + 2) begin
            errors++;
            $display("FAIL check_to_rsp: rsp cycle actual %0d, required %0d", rc, dc + 2);
        end
        check_rsp("humidity", a, code, data, 5'd3, 8'h00, 16'h3500);
    endtask

    task automatic test_bad_frames();
        int acc, sc, dc, rc;
        logic [4:0] sel, a;
        logic [7:0] code;
        logic [15:0] data;
        send_req(5'd7, 2'b01, acc);
        sensor_reply(FR_BAD, 1, sc, sel, dc);
        get_rsp(rc, a, code, data);
        check_rsp("bad_checksum", a, code, data, 5'd7, 8'h1F, 16'hFFFF);
        send_req(5'd7, 2'b01, acc);
        sensor_reply(FR_ONES, 1, sc, sel, dc);
        get_rsp(rc, a, code, data);
        check_rsp("all_ones", a, code, data, 5'd7, 8'h1F, 16'hFFFF);
    endtask

    task automatic test_timeout();
        int acc, sc, dc, rc, s0;
        logic [4:0] sel, a;
        logic [7:0] code;
        logic [15:0] data;
        s0 = n_starts;
        send_req(5'd9, 2'b10, acc);
        sensor_reply(FR_GOOD, -1, sc, sel, dc);
        get_rsp(rc, a, code, data);
        checks++;
        if (rc !== sc + 50) begin
            errors++;
            $display("FAIL timeout_latency: rsp cycle actual %0d, required %0d", rc, sc + 50);
        end
        check_rsp("timeout", a, code, data, 5'd9, 8'h1F, 16'hFFFF);
        repeat (150) @(negedge clk);
        checks++;
        if (n_starts - s0 !== 1) begin
            errors++;
            $display("FAIL timeout_single_start: starts actual %0d, required 1", n_starts - s0);
        end
    endtask

    task automatic test_invalid();
        int acc, rc, s0;
        logic [4:0] a;
        logic [7:0] code;
        logic [15:0] data;
        s0 = n_starts;
        send_req(5'd5, 2'b11, acc);
        get_rsp(rc, a, code, data);
        checks++;
        if (rc !== acc) begin
            errors++;
            $display("FAIL invalid_latency: rsp cycle actual %0d, required %0d", rc, acc);
        end
        check_rsp("invalid_cmd", a, code, data, 5'd5, 8'hE0, 16'h0000);
        checks++;
        if (n_starts !== s0) begin
            errors++;
            $display("FAIL invalid_no_start: starts actual %0d, required %0d", n_starts, s0);
        end
    endtask

    task automatic test_latency();
        int acc, sc, dc, rc;
        logic [4:0] sel, a;
        logic [7:0] code;
        logic [15:0] data;
        send_req(5'd1, 2'b01, acc);
        sensor_reply(FR_GOOD, 1, sc, sel, dc);
        checks++;
        if (sc !== acc + 1 || sel !== 5'd1) begin
            errors++;
            $display("FAIL req_to_start: cycle/sel actual %0d/%0d, required %0d/1", sc, sel, acc + 1);
        end
        get_rsp(rc, a, code, data);
        check_rsp("temperature", a, code, data, 5'd1, 8'h01, 16'h1A00);
    endtask

    task automatic test_status();
        int acc, sc, dc, rc;
        logic [4:0] sel, a;
        logic [7:0] code;
        logic [15:0] data;
        send_req(5'd31, 2'b10, acc);
        sensor_reply(FR_GOOD, 3, sc, sel, dc);
        get_rsp(rc, a, code, data);
        check_rsp("status", a, code, data, 5'd31, 8'h02, 16'h0000);
    endtask

    task automatic test_back_to_back();
        int acc, sc1, dc1, sc2, dc2, rc;
        logic [4:0] sel, a;
        logic [7:0] code;
        logic [15:0] data;
        send_req(5'd2, 2'b00, acc);
        sensor_reply(FR_GOOD, 1, sc1, sel, dc1);
        get_rsp(rc, a, code, data);
        send_req(5'd2, 2'b00, acc);
        sensor_reply(FR_GOOD, 1, sc2, sel, dc2);
        checks++;
        if (sc2 !== dc1 + 1 + 100) begin
            errors++;
            $display("FAIL b2b_gap: second start actual %0d, required %0d", sc2, dc1 + 101);
        end
        get_rsp(rc, a, code, data);
        check_rsp("b2b_second", a, code, data, 5'd2, 8'h00, 16'h3500);
    endtask

    task automatic test_hold();
        int acc, sc, dc, n, bad;
        logic [4:0] sel;
        send_req(5'd4, 2'b01, acc);
        sensor_reply(FR_GOOD, 1, sc, sel, dc);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_addr !== 5'd4 ||
                rsp_code !== 8'h01 || rsp_data !== 16'h1A00) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_stable: unstable cycles actual %0d, required 0", bad);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: valid/ready actual %b%b, required 01", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid();
        int acc, sc, dc, rc, seen;
        logic [4:0] sel, a;
        logic [7:0] code;
        logic [15:0] data;
        send_req(5'd6, 2'b00, acc);
        sensor_reply(FR_GOOD, -1, sc, sel, dc);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || sns_sel !== 5'd0 || sns_start !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: valid/ready/sel/start actual %b/%b/%0d/%b, required 0/0/0/0",
                     rsp_valid, req_ready, sns_sel, sns_start);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        sns_done = 1'b1;
        sns_data = FR_GOOD;
        @(negedge clk);
        sns_done = 1'b0;
        sns_data = '0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: req_ready actual %b, required 1", req_ready);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midreset_no_rsp: rsp_valid cycles actual %0d, required 0", seen);
        end
        send_req(5'd6, 2'b00, acc);
        sensor_reply(FR_GOOD, 1, sc, sel, dc);
        checks++;
        if (sc !== 100) begin
            errors++;
            $display("FAIL midreset_gap: start cycle actual %0d, required 100", sc);
        end
        get_rsp(rc, a, code, data);
        check_rsp("midreset_rsp", a, code, data, 5'd6, 8'h00, 16'h3500);
    endtask

    initial begin
        test_reset();
        test_humidity();
        test_bad_frames();
        test_timeout();
        test_invalid();
        test_latency();
        test_status();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
